// File: rtl/cpu_pkg.sv
// Shared WISC CPU definitions: default widths, opcode constants and the
// fetch-stage state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 16;
  localparam int CPU_INSTR_W = 16;

  localparam logic [3:0]  CPU_HLT_OPCODE = 4'hF;
  localparam logic [15:0] CPU_NOP_INSTR  = 16'h0000;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    HALT_PEND = 2'b01,
    HALTED    = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/if_id_pipe.sv
// Pipeline register with write-enable, flush and a valid bit.
// Flush wins over write-enable; with neither asserted every field holds.
module if_id_pipe
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W    = CPU_ADDR_W,
  parameter int                 INSTR_W   = CPU_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(CPU_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_plus2_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus2,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_plus2_q, pc_plus2_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = NOP_INSTR;
      pc_plus2_d = pc_plus2_in;
      valid_d    = 1'b0;
    end else if (wen) begin
      instr_d    = instr_in;
      pc_plus2_d = pc_plus2_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus2 = pc_plus2_q;
  assign valid    = valid_q;

endmodule

// File: rtl/pc_if_stage.sv
// Fetch stage: program counter, next-PC selection, halt tracking FSM and
// the IF/ID pipeline register.
module pc_if_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W     = CPU_ADDR_W,
  parameter int                 INSTR_W    = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(CPU_NOP_INSTR),
  parameter logic [3:0]         HLT_OPCODE = CPU_HLT_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_wen,
  input  logic               if_id_wen,
  input  logic               if_id_flush,
  input  logic               control_hazard,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               wb_hlt,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus2;
  logic              hlt_fetched;
  logic              pipe_wen;
  logic              pipe_flush;

  assign pc_plus2    = pc_q + ADDR_W'(2);
  assign hlt_fetched = (imem_data[INSTR_W-1 -: 4] == HLT_OPCODE) && if_id_wen && !if_id_flush;

  // Latching an HLT freezes the PC on that same edge so it keeps pointing at the HLT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pipe_wen   = 1'b0;
    pipe_flush = 1'b0;
    case (state_q)
      RUN: begin
        pipe_wen   = if_id_wen;
        pipe_flush = if_id_flush;
        if (hlt_fetched) begin
          state_d = HALT_PEND;
        end else if (control_hazard) begin
          pc_d = branch_target;
        end else if (pc_wen) begin
          pc_d = pc_plus2;
        end
      end
      HALT_PEND: begin
        pipe_flush = if_id_wen || if_id_flush;
        if (wb_hlt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_pipe #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_pipe (
    .clk         (clk),
    .rst         (rst),
    .wen         (pipe_wen),
    .flush       (pipe_flush),
    .instr_in    (imem_data),
    .pc_plus2_in (pc_plus2),
    .instr       (if_id_instr),
    .pc_plus2    (if_id_pc_plus2),
    .valid       (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_pc_if_stage.sv
// Directed scoreboard bench for the fetch stage: each driven cycle queues the
// outputs expected after its clock edge, a monitor compares them on the falling edge.
module tb_pc_if_stage;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        valid;
    logic        halted;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        pc_wen;
  logic        if_id_wen;
  logic        if_id_flush;
  logic        control_hazard;
  logic [15:0] branch_target;
  logic        wb_hlt;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  pc_if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .pc_wen         (pc_wen),
    .if_id_wen      (if_id_wen),
    .if_id_flush    (if_id_flush),
    .control_hazard (control_hazard),
    .branch_target  (branch_target),
    .wb_hlt         (wb_hlt),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int vec, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, vec, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, queue what must follow it.
  task automatic applyStimulus(input logic r, input logic pw, input logic wen, input logic fl,
                               input logic ch, input logic [15:0] bt, input logic wh,
                               input logic [15:0] im, input logic [15:0] e_pc,
                               input logic [15:0] e_instr, input logic [15:0] e_pp2,
                               input logic e_valid, input logic e_halted);
    exp_t e;
    rst            = r;
    pc_wen         = pw;
    if_id_wen      = wen;
    if_id_flush    = fl;
    control_hazard = ch;
    branch_target  = bt;
    wb_hlt         = wh;
    imem_data      = im;
    @(posedge clk);
    e.pc       = e_pc;
    e.instr    = e_instr;
    e.pc_plus2 = e_pp2;
    e.valid    = e_valid;
    e.halted   = e_halted;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vec_id++;
        checkOutput("pc", vec_id, pc, e.pc);
        checkOutput("imem_addr", vec_id, imem_addr, e.pc);
        checkOutput("if_id_instr", vec_id, if_id_instr, e.instr);
        checkOutput("if_id_pc_plus2", vec_id, if_id_pc_plus2, e.pc_plus2);
        checkOutput("if_id_valid", vec_id, {15'b0, if_id_valid}, {15'b0, e.valid});
        checkOutput("halted", vec_id, {15'b0, halted}, {15'b0, e.halted});
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    // rst pw wen fl ch bt wh imem | pc instr pp2 valid halted
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h1234, 16'h0004, 16'h1234, 16'h0004, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0006, 16'h0000, 16'h0006, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h2345, 16'h0008, 16'h2345, 16'h0008, 1, 0);
    // Redirect to 0x0010, then stall two cycles, then release
    applyStimulus(0, 1, 1, 1, 1, 16'h0010, 0, 16'h0000, 16'h0010, 16'h0000, 16'h000A, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h5555, 16'h0010, 16'h0000, 16'h000A, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h5555, 16'h0010, 16'h0000, 16'h000A, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h6666, 16'h0012, 16'h6666, 16'h0012, 1, 0);
    // Move to 0x0020, then branch to 0x0100 with flush
    applyStimulus(0, 1, 1, 1, 1, 16'h0020, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0014, 0, 0);
    applyStimulus(0, 1, 1, 1, 1, 16'h0100, 0, 16'h7777, 16'h0100, 16'h0000, 16'h0022, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h3000, 16'h0102, 16'h3000, 16'h0102, 1, 0);
    // Redirect with pc_wen=0 still redirects
    applyStimulus(0, 0, 1, 1, 1, 16'h0030, 0, 16'h0000, 16'h0030, 16'h0000, 16'h0104, 0, 0);
    // HLT at 0x0030: latch it, PC frozen
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'hF000, 16'h0030, 16'hF000, 16'h0032, 1, 0);
    // HALT_PEND: redirect/pc_wen ignored, bubble loaded
    applyStimulus(0, 1, 1, 0, 1, 16'h0200, 0, 16'h1111, 16'h0030, 16'h0000, 16'h0032, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0030, 16'h0000, 16'h0032, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0030, 16'h0000, 16'h0032, 0, 1);
    // HALTED ignores everything but reset
    applyStimulus(0, 1, 1, 1, 1, 16'h0500, 0, 16'h2222, 16'h0030, 16'h0000, 16'h0032, 0, 1);
    applyStimulus(1, 1, 1, 1, 1, 16'h0500, 1, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    // HLT fetched under flush: redirect proceeds, no halt
    applyStimulus(0, 1, 1, 1, 1, 16'h0200, 0, 16'hF000, 16'h0200, 16'h0000, 16'h0002, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h4000, 16'h0202, 16'h4000, 16'h0202, 1, 0);
    // HLT fetched with if_id_wen=0: nothing changes
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'hF000, 16'h0202, 16'h4000, 16'h0202, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0204, 16'h0000, 16'h0204, 1, 0);
    // Wrap from 0xFFFE
    applyStimulus(0, 1, 1, 1, 1, 16'hFFFE, 0, 16'h0000, 16'hFFFE, 16'h0000, 16'h0206, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0ABC, 16'h0000, 16'h0ABC, 16'h0000, 1, 0);
    // wb_hlt in RUN is ignored
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 1, 0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_if_stage.md
# pc_if_stage

Fetch stage of the five-stage WISC pipeline. It owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It obeys the stall, flush and redirect signals produced by the hazard detection unit: PC write-enable, IF/ID write-enable, IF/ID flush, and branch redirect. It also tracks HLT so fetch freezes once a halt has entered the pipe.

## Interface
Parameters:
- ADDR_W, 16, PC / address width
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value after reset
- NOP_INSTR, 16'h0000, encoding loaded into IF/ID on flush or bubble
- HLT_OPCODE, 4'hF, opcode (instr[15:12]) of HLT

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_wen  in  1  hazard unit: 1 = PC may advance
- if_id_wen  in  1  hazard unit: 1 = IF/ID may load
- if_id_flush  in  1  hazard unit: squash the instruction being fetched
- control_hazard  in  1  redirect: next PC = branch_target
- branch_target  in  ADDR_W  resolved branch address from ID
- wb_hlt  in  1  HLT has reached writeback
- imem_addr  out  ADDR_W  instruction-memory address (= pc, combinational)
- imem_data  in  INSTR_W  instruction read at imem_addr, same cycle
- pc  out  ADDR_W  current PC
- if_id_instr  out  INSTR_W  registered instruction
- if_id_pc_plus2  out  ADDR_W  registered pc+2 of that instruction
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction
- halted  out  1  processor halted (sticky until reset)

## Operation
- State machine with three states:
  - RUN: normal fetch.
  - HALT_PEND: an HLT was latched into IF/ID; PC frozen; IF/ID loads bubbles.
  - HALTED: terminal; halted=1.
- Next PC in RUN:
  - control_hazard=1: pc loads branch_target. Redirect overrides pc_wen=0.
  - else pc_wen=1: pc loads pc+2. Modulo 2^ADDR_W, so 16'hFFFE -> 16'h0000.
  - else pc holds.
- IF/ID register, in priority order:
  - if_id_flush=1: instr=NOP_INSTR, valid=0, pc_plus2 = pc+2. Flush beats if_id_wen.
  - else if_id_wen=1: instr=imem_data, valid=1, pc_plus2 = pc+2.
  - else hold all three fields.
- RUN -> HALT_PEND when all hold: imem_data[15:12]==HLT_OPCODE, if_id_wen=1, if_id_flush=0. The HLT itself is latched with valid=1.
- An HLT fetched while flush=1 or if_id_wen=0 does not change state. A flush on the same cycle also cancels the halt; the redirect proceeds.
- HALT_PEND:
  - pc holds; control_hazard and pc_wen are ignored.
  - IF/ID loads NOP_INSTR with valid=0 whenever if_id_wen=1 or if_id_flush=1; otherwise it holds.
- HALT_PEND -> HALTED on wb_hlt=1. HALTED holds pc and IF/ID, and ignores all inputs except rst.
- wb_hlt in RUN is ignored (protocol error; not reachable).

## Timing
- Reset values, applied on the first rising edge with rst=1:
  - pc=RESET_PC, state=RUN
  - if_id_instr=NOP_INSTR, if_id_pc_plus2=0, if_id_valid=0, halted=0
- imem_addr follows pc with zero latency.
- Latency: the instruction at pc appears on if_id_instr one edge after fetch, provided if_id_wen=1.
- Redirect: branch_target appears on pc one edge after control_hazard. The instruction at branch_target reaches IF/ID on the following edge.
- halted rises one edge after wb_hlt is sampled in HALT_PEND.
- rst mid-operation, in any state, overrides every other input on that edge.

## Structure
- Shared package (cpu_pkg) holds:
  - opcode constants (HLT_OPCODE, NOP_INSTR)
  - the fetch-state encoding (RUN=2'b00, HALT_PEND=2'b01, HALTED=2'b10)
  - ADDR_W / INSTR_W defaults
- One sub-module: if_id_pipe. It contains the IF/ID register with wen/flush priority and valid bit, and is reused by the ID/EX stall-flush logic.
- PC register, next-PC mux and state machine live in pc_if_stage.

## Test plan
- Reset then 4 cycles with pc_wen=if_id_wen=1 and NOP imem -> pc 0,2,4,6,8; valid rises on the first post-reset edge; if_id_pc_plus2 = 2,4,6,8.
- pc=16'h0010 with pc_wen=0 and if_id_wen=0 for 2 cycles -> pc and IF/ID frozen; release -> pc=16'h0012.
- pc=16'h0020, control_hazard=1, flush=1, branch_target=16'h0100 -> pc=16'h0100, IF/ID NOP valid=0; next edge if_id_pc_plus2=16'h0102.
- HLT (16'hF000) fetched at 16'h0030 -> IF/ID holds F000 valid=1, pc frozen at 16'h0030; following edges load bubbles; wb_hlt=1 -> halted=1 next edge.
- HLT fetched with flush=1 and branch_target=16'h0200 -> state stays RUN, pc=16'h0200, no halt.
- pc=16'hFFFE advancing -> pc=16'h0000; rst asserted in HALTED -> all outputs return to reset values in one edge.
